// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the shift-add multiplier.
//               Holds the controller state encoding and the ALU op-codes
//               understood by shift_add_multiplier_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Controller states: IDLE waits for start, CALC runs N add/shift steps,
    // DONE presents the product for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_multiplier_alu.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_alu
// Description : N-bit combinational ALU (ADD / SUB / AND / OR) with
//               overflow (V), carry (C), negative (Neg) and zero (Z) flags.
// Parameters  : N        - operand width
// Ports       : i_a      - operand A
//               i_b      - operand B
//               i_op     - operation code (ALU_* from mult_pkg)
//               o_result - N-bit result
//               o_v      - signed overflow
//               o_c      - carry-out for ADD, not-borrow for SUB, 0 otherwise
//               o_neg    - result MSB
//               o_z      - result is zero
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier_alu
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_op,
    output logic [N-1:0] o_result,
    output logic         o_v,
    output logic         o_c,
    output logic         o_neg,
    output logic         o_z
);

    logic [N:0] w_sum;
    logic [N:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_v      = 1'b0;
        o_c      = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result = w_sum[N-1:0];
                o_c      = w_sum[N];
                o_v      = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            ALU_SUB: begin
                o_result = w_diff[N-1:0];
                // Borrow appears in bit N; C reports "no borrow"
                o_c      = ~w_diff[N];
                o_v      = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            default: o_result = '0;
        endcase
    end

    assign o_neg = o_result[N-1];
    assign o_z   = (o_result == '0);

endmodule : shift_add_multiplier_alu
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential N x N shift-and-add multiplier. One add/shift
//               step per clock; a product takes N CALC cycles followed by a
//               one-cycle DONE pulse.
// Config      : MULT_SIGNED_EN - when defined, A/B/P are two's complement.
//               Operand magnitudes feed the unsigned core and the product is
//               negated on load into P when the operand signs differ.
// Parameters  : N     - operand width (>= 2)
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               start - begin a multiply (sampled only in IDLE)
//               A, B  - multiplicand / multiplier, captured on accepted start
//               P     - 2N-bit product, held until the next accepted start
//               busy  - high while in CALC
//               done  - one-cycle pulse, P valid
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N) + 1;

    mult_state_t    r_state;
    mult_state_t    w_next_state;

    logic [N-1:0]   r_mcand;
    logic [2*N-1:0] r_acc;
    logic           r_carry;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_p;

    logic [N-1:0]   w_addend;
    logic [N-1:0]   w_sum;
    logic           w_cout;
    logic [2*N-1:0] w_acc_next;
    logic           w_last;
    logic [N-1:0]   w_cap_a;
    logic [N-1:0]   w_cap_b;
    logic [2*N-1:0] w_p_load;

    // Flags not needed by the multiply step
    logic           w_unused_v;
    logic           w_unused_neg;
    logic           w_unused_z;
    // The carry bit is always shifted back to zero by the end of a step;
    // it is kept as state so {C, upper, lower} forms one register.
    logic           w_unused_carry;

    assign w_unused_carry = r_carry;

    // ------------------------------------------------------------------
    // Datapath: upper half + (LSB ? multiplicand : 0), then shift right
    // ------------------------------------------------------------------
    assign w_addend = r_acc[0] ? r_mcand : '0;

    shift_add_multiplier_alu #(
        .N (N)
    ) u_alu (
        .i_a      (r_acc[2*N-1:N]),
        .i_b      (w_addend),
        .i_op     (ALU_ADD),
        .o_result (w_sum),
        .o_v      (w_unused_v),
        .o_c      (w_cout),
        .o_neg    (w_unused_neg),
        .o_z      (w_unused_z)
    );

    // {C, sum, lower} >> 1 : carry drops into the accumulator MSB
    assign w_acc_next = {w_cout, w_sum, r_acc[N-1:1]};
    assign w_last     = (r_cnt == CW'(N - 1));

`ifdef MULT_SIGNED_EN
    logic r_neg;

    // -(-2^(N-1)) wraps to 2^(N-1), which is still the correct unsigned
    // magnitude in N bits.
    assign w_cap_a  = A[N-1] ? -A : A;
    assign w_cap_b  = B[N-1] ? -B : B;
    assign w_p_load = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg <= 1'b0;
        end else if ((r_state == IDLE) && start) begin
            r_neg <= A[N-1] ^ B[N-1];
        end
    end
`else
    assign w_cap_a  = A;
    assign w_cap_b  = B;
    assign w_p_load = w_acc_next;
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= w_cap_a;
                        r_acc   <= {{N{1'b0}}, w_cap_b};
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_acc   <= w_acc_next;
                    r_carry <= 1'b0;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_p <= w_p_load;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign P = r_p;

endmodule : shift_add_multiplier
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Scoreboard testbench for shift_add_multiplier. Stimulus
//               pushes expected {P, done cycle}; a monitor pops and compares
//               on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] P;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    shift_add_multiplier #(
        .N (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [2*N-1:0] p;
        int             cyc;
        int             id;
    } exp_t;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    exp_t q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle=%0d P=%0h required no pulse", cyc, P);
            end else begin
                e = q.pop_front();
                check($sformatf("P_op%0d", e.id), P, e.p);
                check($sformatf("done_cycle_op%0d", e.id), cyc, e.cyc);
                check($sformatf("busy_cycles_op%0d", e.id), busy_run, N);
            end
        end
        if (busy) busy_run++;
        else if (!done) busy_run = 0;
    end

    // Called at a negedge: start accepted at the following posedge
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] p, input int id);
        A     = a;
        B     = b;
        start = 1'b1;
        q.push_back('{p: p, cyc: cyc + 1 + N, id: id});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4 * N; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, q.size());
            q.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[8];

    initial begin : stim
        int c0;
`ifdef MULT_SIGNED_EN
        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'hFF,  8'hFF,  16'h0001};
        vecs[2] = '{8'h00,  8'hAB,  16'h0000};
        vecs[3] = '{8'hAB,  8'h00,  16'h0000};
        vecs[4] = '{8'h80,  8'h7F,  16'hC080};
        vecs[5] = '{8'hFD,  8'h05,  16'hFFF1};
        vecs[6] = '{8'h80,  8'h80,  16'h4000};
        vecs[7] = '{8'h01,  8'hFF,  16'hFFFF};
`else
        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
        vecs[2] = '{8'h00,  8'hAB,  16'h0000};
        vecs[3] = '{8'hAB,  8'h00,  16'h0000};
        vecs[4] = '{8'h80,  8'h7F,  16'h3F80};
        vecs[5] = '{8'hFD,  8'h05,  16'h04F1};
        vecs[6] = '{8'h80,  8'h80,  16'h4000};
        vecs[7] = '{8'h01,  8'hFF,  16'h00FF};
`endif
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("reset_P", P, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Directed vectors, one at a time; P must hold afterwards
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].p, i);
            @(negedge clk);
            start = 1'b0;
            drain($sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
            check($sformatf("P_hold_vec%0d", i), P, vecs[i].p);
        end

        // start held across two operations: 7*6 then 9*9
        @(negedge clk);
        c0 = cyc;
        issue(8'd7, 8'd6, 16'd42, 100);
        q.push_back('{p: 16'd81, cyc: c0 + 1 + N + N + 2, id: 101});
        @(negedge clk);
        A = 8'd9;
        B = 8'd9;
        repeat (N + 2) @(negedge clk);
        start = 1'b0;
        drain("back_to_back");

        // reset during the 4th CALC cycle discards the op
        @(negedge clk);
        A     = 8'd50;
        B     = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_P", P, 0);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        repeat (N + 4) @(negedge clk);
        issue(8'd2, 8'd3, 16'd6, 200);
        @(negedge clk);
        start = 1'b0;
        drain("after_reset");

        // start pulses during CALC must be ignored
        @(negedge clk);
        issue(8'd100, 8'd50, 16'd5000, 300);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        A     = 8'd1;
        B     = 8'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("start_in_calc");
        repeat (N + 4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_add_multiplier
`default_nettype wire

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter N, default 8: operand width in bits; N SHALL be at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 A  input  N  multiplicand; captured when start is accepted.
REQ-006 B  input  N  multiplier; captured when start is accepted.
REQ-007 P  output  2N  product register; holds its value until the next accepted start.
REQ-008 busy  output  1  high while in CALC.
REQ-009 done  output  1  one-cycle pulse; P is valid in that cycle.

Function
REQ-010 FSM states SHALL be IDLE, CALC and DONE.
REQ-011 IDLE with start=1 SHALL capture A into the multiplicand register and B into the low half of the accumulator, clear the upper half and the carry bit, and move to CALC.
REQ-012 IDLE with start=0 SHALL hold all registers.
REQ-013 Each CALC cycle, if the accumulator LSB is 1, the accumulator upper half SHALL be upper + multiplicand (ADD, carry-out C kept).
REQ-014 Otherwise the upper half SHALL be added with 0.
REQ-015 Each CALC cycle the concatenation {C, upper, lower} SHALL then shift right by 1.
REQ-016 An iteration counter of width clog2(N)+1 SHALL run for exactly N CALC cycles, then move to DONE.
REQ-017 On the CALC-to-DONE transition, P SHALL load the 2N-bit accumulator.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge k -> busy=1 in cycles k+1..k+N -> done=1 in cycle k+N+1.
REQ-020 start SHALL be ignored in CALC and DONE; an in-flight operation SHALL never restart or abort except by reset.
REQ-021 start held continuously SHALL be re-accepted in the IDLE cycle after DONE, giving back-to-back ops every N+2 cycles.
REQ-022 Unsigned product SHALL be exact for all operands, including (2^N-1)*(2^N-1), with no truncation.

Reset
REQ-023 reset=1 SHALL force IDLE with P=0, busy=0, done=0, and counter, accumulator, multiplicand and carry all 0.
REQ-024 reset SHALL take priority over start and over any state.
REQ-025 reset asserted mid-CALC SHALL discard the operation and produce no done pulse.

Configuration
REQ-026 Macro MULT_SIGNED_EN defined: A and B SHALL be two's complement.
REQ-027 With MULT_SIGNED_EN, operand magnitudes SHALL be captured at start, the unsigned core run unchanged, and the product negated when loading P if the operand signs differ.
REQ-028 With MULT_SIGNED_EN, P SHALL be a 2N-bit two's-complement value; (-2^(N-1))*(-2^(N-1)) SHALL yield +2^(2N-2).
REQ-029 Latency SHALL be identical with and without MULT_SIGNED_EN.
REQ-030 Macro undefined: operands and P SHALL be unsigned, with no sign logic synthesized.

Structure
REQ-031 A shared package mult_pkg SHALL hold the state enum type mult_state_t (IDLE, CALC, DONE).
REQ-032 mult_pkg SHALL also hold the ALU operation-code constants: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
REQ-033 The add step SHALL instantiate the team's existing N-bit ALU sub-module (the ADD/SUB/AND/OR unit with V, C, Neg, Z flags), driven with ALU_ADD.
REQ-034 The add step SHALL use the ALU Result and C outputs; the V, Neg and Z flags SHALL be left unused.

Verification
REQ-035 Reset then start with A=8'd13, B=8'd11 -> busy high 8 cycles, done in cycle 9 with P=16'd143.
REQ-036 A=8'hFF, B=8'hFF (unsigned build) -> P=16'hFE01; A=0, B=8'hAB -> P=16'h0000.
REQ-037 MULT_SIGNED_EN build: A=-3 (8'hFD), B=5 -> P=16'hFFF1; A=8'h80, B=8'h80 -> P=16'h4000.
REQ-038 Start held high across two ops (7*6, then 9*9) -> second start accepted in IDLE after DONE; P=42 then P=81, with done pulses 10 cycles apart.
REQ-039 reset asserted in the 4th CALC cycle -> next cycle IDLE, P=0, done never asserted; a following op 2*3 -> P=6.
REQ-040 start toggled high during CALC -> ignored; P and timing match the uninterrupted result.
